// File: rtl/cla_result_accumulator_pkg.sv
// Shared definitions for the CLA result path: default slice/accumulator widths and FSM encodings.
// Kept common with the CLA stage so the slice width seen here always matches the producer.
package cla_result_accumulator_pkg;

   localparam int DATA_W_DEF  = 4;
   localparam int ACC_W_DEF   = 12;
   localparam int COUNT_W_DEF = 8;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_ACCUM = 2'd1,
      ST_HOLD  = 2'd2
   } acc_state_t;

endpackage

// File: rtl/cla_result_accumulator_sat_counter.sv
// Saturating up-counter with synchronous clear (clear wins over enable); 1-cycle update latency.
// No backpressure: counts every enabled cycle, sticks at all-ones.
module sat_counter
   import cla_result_accumulator_pkg::*;
#(
   parameter int W = COUNT_W_DEF
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         clr,
   input  logic         en,
   output logic [W-1:0] cnt
);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt <= '0;
      end else if (clr) begin
         cnt <= '0;
      end else if (en && (cnt != {W{1'b1}})) begin
         cnt <= cnt + W'(1);
      end
   end

endmodule

// File: rtl/cla_result_accumulator.sv
// Accumulates a programmed number of CLA {cout,sum} results; out_valid rises on the edge registering the last sample.
// Result held in HOLD until out_ready; start while busy is dropped, in_valid outside ACCUM is ignored.
module cla_result_accumulator
   import cla_result_accumulator_pkg::*;
#(
   parameter int DATA_W  = DATA_W_DEF,
   parameter int ACC_W   = ACC_W_DEF,
   parameter int COUNT_W = COUNT_W_DEF
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic               start,
   input  logic [COUNT_W-1:0] num_samples,
   input  logic               in_valid,
   input  logic [DATA_W-1:0]  in_sum,
   input  logic               in_cout,
   input  logic               out_ready,
   output logic               out_valid,
   output logic [ACC_W-1:0]   acc_out,
   output logic [COUNT_W-1:0] carry_cnt,
   output logic               overflow,
   output logic               busy
);

   acc_state_t         state;
   logic [COUNT_W-1:0] num_lat;
   logic [COUNT_W-1:0] smp_cnt;
   logic [ACC_W:0]     sum_ext;
   logic               start_ok;
   logic               take;
   logic               last;

   assign start_ok = (state == ST_IDLE) && start;
   assign take     = (state == ST_ACCUM) && in_valid;
   // One extra bit on the adder exposes the wrap that drives the sticky overflow.
   assign sum_ext  = {1'b0, acc_out} + {{(ACC_W - DATA_W){1'b0}}, in_cout, in_sum};
   assign last     = (smp_cnt == (num_lat - COUNT_W'(1)));

   sat_counter #(.W(COUNT_W)) u_carry_cnt (
      .clk   (clk),
      .rst_n (rst_n),
      .clr   (start_ok),
      .en    (take && in_cout),
      .cnt   (carry_cnt)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state     <= ST_IDLE;
         num_lat   <= '0;
         smp_cnt   <= '0;
         acc_out   <= '0;
         overflow  <= 1'b0;
         out_valid <= 1'b0;
         busy      <= 1'b0;
      end else begin
         case (state)
            ST_IDLE: begin
               if (start) begin
                  num_lat  <= num_samples;
                  smp_cnt  <= '0;
                  acc_out  <= '0;
                  overflow <= 1'b0;
                  busy     <= 1'b1;
                  if (num_samples == '0) begin
                     state     <= ST_HOLD;
                     out_valid <= 1'b1;
                  end else begin
                     state <= ST_ACCUM;
                  end
               end
            end
            ST_ACCUM: begin
               if (in_valid) begin
                  acc_out  <= sum_ext[ACC_W-1:0];
                  overflow <= overflow | sum_ext[ACC_W];
                  smp_cnt  <= smp_cnt + COUNT_W'(1);
                  if (last) begin
                     state     <= ST_HOLD;
                     out_valid <= 1'b1;
                  end
               end
            end
            ST_HOLD: begin
               if (out_ready) begin
                  state     <= ST_IDLE;
                  out_valid <= 1'b0;
                  busy      <= 1'b0;
               end
            end
            default: begin
               state     <= ST_IDLE;
               out_valid <= 1'b0;
               busy      <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_cla_result_accumulator.sv
// Table-driven and randomized checks of the CLA result accumulator against a plain-arithmetic model.
module tb_cla_result_accumulator;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        start = 1'b0;
   logic [7:0]  num_samples = '0;
   logic        in_valid = 1'b0;
   logic [3:0]  in_sum = '0;
   logic        in_cout = 1'b0;
   logic        out_ready = 1'b0;
   logic        out_valid;
   logic [11:0] acc_out;
   logic [7:0]  carry_cnt;
   logic        overflow;
   logic        busy;

   cla_result_accumulator dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .start       (start),
      .num_samples (num_samples),
      .in_valid    (in_valid),
      .in_sum      (in_sum),
      .in_cout     (in_cout),
      .out_ready   (out_ready),
      .out_valid   (out_valid),
      .acc_out     (acc_out),
      .carry_cnt   (carry_cnt),
      .overflow    (overflow),
      .busy        (busy)
   );

   always #5 clk = ~clk;

   typedef struct {
      int n;
      int pat;       // 0 = basic six CLA results, 1 = all 31, 2 = random
      int max_gap;
      int exp_acc;   // -1: take expectation from the reference model
      int exp_carry;
      int exp_ovf;
   } vec_t;

   int errors = 0;
   int checks = 0;
   int m_total;
   int m_carry;
   int basic_v[6] = '{5, 9, 15, 4, 12, 16};
   vec_t vecs[$];

   task automatic chk(input string name, input int act, input int exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d", name, act, exp);
      end
   endtask

   task automatic chk_zero_outputs(input string tag);
      chk({tag, "_out_valid"}, int'(out_valid), 0);
      chk({tag, "_acc_out"}, int'(acc_out), 0);
      chk({tag, "_carry_cnt"}, int'(carry_cnt), 0);
      chk({tag, "_overflow"}, int'(overflow), 0);
      chk({tag, "_busy"}, int'(busy), 0);
   endtask

   // Starts a run (with a junk valid sample on the start cycle) and feeds n samples.
   task automatic feed(input int n, input int pat, input int max_gap, input int stop_after);
      int early;
      int v;
      int g;
      early   = 0;
      m_total = 0;
      m_carry = 0;
      @(negedge clk);
      start       = 1'b1;
      num_samples = 8'(n);
      in_valid    = 1'b1;
      in_sum      = 4'hf;
      in_cout     = 1'b1;
      @(negedge clk);
      start    = 1'b0;
      in_valid = 1'b0;
      for (int k = 0; k < n && k < stop_after; k++) begin
         g = (max_gap > 0) ? int'($urandom_range(0, max_gap)) : 0;
         for (int j = 0; j < g; j++) begin
            in_valid = 1'b0;
            in_sum   = 4'($urandom);
            in_cout  = 1'($urandom);
            @(negedge clk);
            if (out_valid) early++;
         end
         if (pat == 0) v = basic_v[k];
         else if (pat == 1) v = 31;
         else v = int'($urandom_range(0, 31));
         m_total += v;
         m_carry += v[4];
         in_valid = 1'b1;
         in_cout  = v[4];
         in_sum   = v[3:0];
         @(negedge clk);
         if (k < n - 1 && out_valid) early++;
      end
      in_valid = 1'b0;
      chk("no_early_out_valid", early, 0);
   endtask

   task automatic release_hold(input int exp_acc);
      out_ready = 1'b1;
      @(negedge clk);
      out_ready = 1'b0;
      chk("released_out_valid", int'(out_valid), 0);
      chk("released_busy", int'(busy), 0);
      chk("idle_keeps_acc", int'(acc_out), exp_acc);
   endtask

   initial begin
      int ea, ec, eo;
      vecs.push_back('{6, 0, 0, 61, 1, 0});
      vecs.push_back('{6, 0, 3, 61, 1, 0});
      vecs.push_back('{140, 1, 0, 244, 140, 1});
      vecs.push_back('{0, 0, 0, 0, 0, 0});
      vecs.push_back('{1, 2, 0, -1, 0, 0});
      for (int i = 0; i < 6; i++) vecs.push_back('{int'($urandom_range(2, 40)), 2, 2, -1, 0, 0});
      vecs.push_back('{255, 2, 1, -1, 0, 0});

      #2;
      chk_zero_outputs("reset");
      @(negedge clk);
      rst_n = 1'b1;

      foreach (vecs[i]) begin
         feed(vecs[i].n, vecs[i].pat, vecs[i].max_gap, 1000);
         if (vecs[i].exp_acc < 0) begin
            ea = m_total % 4096;
            ec = (m_carry > 255) ? 255 : m_carry;
            eo = (m_total >= 4096) ? 1 : 0;
         end else begin
            ea = vecs[i].exp_acc;
            ec = vecs[i].exp_carry;
            eo = vecs[i].exp_ovf;
         end
         chk("done_out_valid", int'(out_valid), 1);
         chk("done_busy", int'(busy), 1);
         chk("acc_out", int'(acc_out), ea);
         chk("carry_cnt", int'(carry_cnt), ec);
         chk("overflow", int'(overflow), eo);
         release_hold(ea);
      end

      // Backpressure: HOLD ignores start and in_valid while out_ready is low.
      feed(6, 0, 0, 1000);
      for (int c = 0; c < 5; c++) begin
         start       = 1'b1;
         num_samples = 8'd3;
         in_valid    = 1'b1;
         in_sum      = 4'($urandom);
         in_cout     = 1'b1;
         @(negedge clk);
         chk("bp_out_valid", int'(out_valid), 1);
         chk("bp_busy", int'(busy), 1);
         chk("bp_acc_out", int'(acc_out), 61);
         chk("bp_carry_cnt", int'(carry_cnt), 1);
      end
      start    = 1'b0;
      in_valid = 1'b0;
      release_hold(61);

      // Reset mid-run takes effect without waiting for a clock edge.
      feed(6, 0, 0, 2);
      chk("midrun_busy", int'(busy), 1);
      rst_n = 1'b0;
      #1;
      chk_zero_outputs("midrun_reset");
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      start       = 1'b1;
      num_samples = 8'd1;
      @(negedge clk);
      start    = 1'b0;
      in_valid = 1'b1;
      in_sum   = 4'd9;
      in_cout  = 1'b0;
      @(negedge clk);
      in_valid = 1'b0;
      chk("post_reset_out_valid", int'(out_valid), 1);
      chk("post_reset_acc_out", int'(acc_out), 9);
      chk("post_reset_carry_cnt", int'(carry_cnt), 0);
      release_hold(9);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
